// File: rtl/dram_uart_dump.sv
// dram_uart_dump: 32 x 8 distributed RAM bank with a synchronous write port and
// a UART (8N1) transmitter that streams the whole bank, address 0..31, on request.
//
// Ports:
//   clk        - system clock, all logic on rising edge
//   rst        - synchronous active-high reset (RAM contents untouched)
//   wr_en      - write strobe; ignored while a dump is running
//   wr_addr    - write address (5 bits)
//   wr_data    - write data (8 bits)
//   dump_start - level-sampled dump request, honoured only when idle
//   tx         - UART serial out, idle high
//   busy       - high for the whole dump
//   done       - one-cycle pulse in the cycle busy falls
module dram_uart_dump #(
  parameter int            CLKS_PER_BIT = 868,
  parameter logic [255:0]  INIT         = 256'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       dump_start,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Packed so byte k maps straight onto INIT[8k+7:8k]; loaded at configuration.
  logic [31:0][7:0] mem_q = INIT;

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [4:0]  addr_q, addr_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        baud_end;

  // Writes are frozen during a dump so the streamed image is coherent.
  // The read below is asynchronous, so a same-edge write + load sees the old byte.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) mem_q[wr_addr] <= wr_data;
  end

  assign baud_end = (baud_q == BAUD_MAX);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    addr_d  = addr_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (dump_start) begin
          addr_d  = 5'd0;
          sh_d    = mem_q[0];
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          tx_d    = sh_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];  // next LSB after the shift
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (addr_q != 5'd31) begin
            // Next start bit begins immediately: no inter-frame gap.
            addr_d  = addr_q + 5'd1;
            sh_d    = mem_q[addr_q + 5'd1];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            addr_d  = 5'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      addr_q  <= 5'd0;
      sh_q    <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      addr_q  <= addr_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_dram_uart_dump.sv
module tb_dram_uart_dump;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = 5'd0;
  logic [7:0] wr_data = 8'd0;
  logic       dump_start = 1'b0;
  logic       tx, busy, done;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_mem [32];

  dram_uart_dump #(.CLKS_PER_BIT(CPB), .INIT(256'h0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dump_start(dump_start), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int idx, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, got, exp);
    end
  endtask

  // Expected per-cycle tx waveform of one frame; bit i = tx in cycle i of the frame.
  function automatic logic [39:0] wave(input logic [7:0] b);
    logic [39:0] w;
    for (int i = 0; i < 10 * CPB; i++) begin
      int bi;
      bi = i / CPB;
      if (bi == 0)      w[i] = 1'b0;
      else if (bi == 9) w[i] = 1'b1;
      else              w[i] = b[bi - 1];
    end
    return w;
  endfunction

  // Entered at the negedge of the first cycle of frame 0. Captures nf frames
  // cycle by cycle and compares each to the expected waveform.
  task automatic run_frames(input int nf, input bit full);
    int busy_cnt, done_cnt;
    logic [39:0] cap;
    busy_cnt = 0;
    done_cnt = 0;
    for (int f = 0; f < nf; f++) begin
      cap = '0;
      for (int c = 0; c < 10 * CPB; c++) begin
        cap[c] = tx;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
        @(negedge clk);
      end
      check("frame", f, 64'(cap), 64'(wave(exp_mem[f])));
    end
    if (full) begin
      check("busy_cycles", 0, 64'(busy_cnt), 64'(320 * CPB));
      check("done_during", 0, 64'(done_cnt), 64'd0);
      check("end_busy", 0, 64'(busy), 64'd0);
      check("end_done", 0, 64'(done), 64'd1);
      check("end_tx", 0, 64'(tx), 64'd1);
    end
  endtask

  // Pulse dump_start for one edge; leaves us in the first cycle of frame 0.
  task automatic start_dump();
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    check("latency_tx", 0, 64'(tx), 64'd0);
    check("latency_busy", 0, 64'(busy), 64'd1);
  endtask

  task automatic after_done_idle();
    @(negedge clk);
    check("done_pulse_off", 0, 64'(done), 64'd0);
    check("idle_busy", 0, 64'(busy), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) exp_mem[k] = 8'h00;

    // Reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("idle_tx", i, 64'(tx), 64'd1);
      check("idle_busy", i, 64'(busy), 64'd0);
      check("idle_done", i, 64'(done), 64'd0);
      @(negedge clk);
    end

    // Dump of INIT contents (all zero)
    start_dump();
    run_frames(32, 1'b1);
    after_done_idle();

    // Write k ^ 0xA5 pattern
    for (int k = 0; k < 32; k++) begin
      wr_en   = 1'b1;
      wr_addr = 5'(k);
      wr_data = 8'(k) ^ 8'hA5;
      exp_mem[k] = 8'(k) ^ 8'hA5;
      @(negedge clk);
    end
    wr_en = 1'b0;
    start_dump();
    run_frames(32, 1'b1);
    after_done_idle();

    // Write to addr 31 held throughout a dump must be dropped
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 5'd31;
    wr_data = 8'hFF;
    run_frames(32, 1'b1);
    wr_en = 1'b0;
    after_done_idle();
    start_dump();
    run_frames(32, 1'b1);
    after_done_idle();

    // Back-to-back dumps with dump_start held high
    dump_start = 1'b1;
    @(negedge clk);
    run_frames(32, 1'b1);
    @(negedge clk);
    check("b2b_restart_tx", 0, 64'(tx), 64'd0);
    check("b2b_restart_busy", 0, 64'(busy), 64'd1);
    check("b2b_restart_done", 0, 64'(done), 64'd0);
    run_frames(32, 1'b1);
    dump_start = 1'b0;
    after_done_idle();

    // Reset during bit 3 of frame 5
    start_dump();
    run_frames(5, 1'b0);
    repeat (CPB + 3 * CPB + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_tx", 0, 64'(tx), 64'd1);
    check("rst_busy", 0, 64'(busy), 64'd0);
    check("rst_done", 0, 64'(done), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_no_done", i, 64'(done), 64'd0);
      check("rst_idle_tx", i, 64'(tx), 64'd1);
    end
    start_dump();
    run_frames(32, 1'b1);
    after_done_idle();

    // Same-edge write and dump_start: frame 0 carries the old byte
    wr_en      = 1'b1;
    wr_addr    = 5'd0;
    wr_data    = 8'h3C;
    dump_start = 1'b1;
    @(negedge clk);
    wr_en      = 1'b0;
    dump_start = 1'b0;
    run_frames(32, 1'b1);
    after_done_idle();
    exp_mem[0] = 8'h3C;
    start_dump();
    run_frames(32, 1'b1);
    after_done_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
